// File: rtl/ioctl_dl_router_if.sv
// Download bus between hps_io, ioctl_dl_router and the machine targets.
// The master modport is the hps_io/target side; the slave modport is the router.
interface ioctl_dl_router_if #(
  parameter int NSLOTS = 4,
  parameter int AW     = 16,
  parameter int DW     = 8
) ();
  localparam int SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  logic              ioctl_download;
  logic              ioctl_wr;
  logic [AW-1:0]     ioctl_addr;
  logic [DW-1:0]     ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait;
  logic              dn_wr;
  logic              dn_ready;
  logic [AW-1:0]     dn_addr;
  logic [DW-1:0]     dn_data;
  logic [SW-1:0]     dn_slot;
  logic [NSLOTS-1:0] slot_active;
  logic [NSLOTS-1:0] slot_done;
  logic [AW:0]       dn_len;
  logic              bad_index;
  logic              overflow;
  logic              core_reset;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, dn_ready,
    input  ioctl_wait, dn_wr, dn_addr, dn_data, dn_slot, slot_active, slot_done,
           dn_len, bad_index, overflow, core_reset
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, dn_ready,
    output ioctl_wait, dn_wr, dn_addr, dn_data, dn_slot, slot_active, slot_done,
           dn_len, bad_index, overflow, core_reset
  );
endinterface

// File: rtl/ioctl_dl_router.sv
// Steers the hps_io download byte stream through a FWFT FIFO to one of NSLOTS targets,
// reporting per-slot completion/length and holding the core in reset around ROM loads.
module ioctl_dl_router #(
  parameter int NSLOTS     = 4,
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ROM_INDEX  = 0,
  parameter int RESET_HOLD = 16
) (
  input logic             clk_sys,
  input logic             reset,
  ioctl_dl_router_if.slave bus
);
  localparam int SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [PW:0]   FULL_LVL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   WAIT_LVL  = (PW+1)'(FIFO_DEPTH - 2);
  localparam logic [AW:0]   CNT_MAX   = {1'b1, {AW{1'b0}}};
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [8:0]    NSLOTS_W  = 9'(NSLOTS);
  localparam logic [7:0]    ROM_W     = 8'(ROM_INDEX);

  logic [1:0]        state_q, state_d;
  logic [7:0]        curIdx_q, curIdx_d;
  logic [7:0]        pendIdx_q, pendIdx_d;
  logic              pend_q, pend_d;
  logic              dlPrev_q;
  logic [AW:0]       byteCnt_q, byteCnt_d;
  logic [HW-1:0]     holdCnt_q, holdCnt_d;
  logic              badIndex_q, badIndex_d;
  logic              overflow_q;
  logic [NSLOTS-1:0] slotDone_q;
  logic [AW:0]       dnLen_q;
  logic              coreReset_q, coreReset_d;

  logic [AW-1:0] memAddr [FIFO_DEPTH];
  logic [DW-1:0] memData [FIFO_DEPTH];
  logic [SW-1:0] memSlot [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [PW:0]   count_q;

  logic              rise, validSlot, isRom, full, pop, wrAttempt, push, ovfl;
  logic              doneNow, startNow;
  logic [7:0]        startIdx;
  logic [NSLOTS-1:0] slotOneHot;

  assign rise      = bus.ioctl_download && !dlPrev_q;
  assign validSlot = {1'b0, curIdx_q} < NSLOTS_W;
  assign isRom     = curIdx_q == ROM_W;
  assign full      = count_q == FULL_LVL;
  assign pop       = (count_q != '0) && bus.dn_ready;
  assign wrAttempt = (state_q == S_ACTIVE) && bus.ioctl_wr && validSlot;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign push      = wrAttempt && (!full || pop);
  assign ovfl      = wrAttempt && full && !pop;

  always_comb begin
    slotOneHot = '0;
    for (int i = 0; i < NSLOTS; i++) slotOneHot[i] = ({1'b0, curIdx_q} == 9'(i));
  end

  always_comb begin
    state_d    = state_q;
    curIdx_d   = curIdx_q;
    pendIdx_d  = pendIdx_q;
    pend_d     = pend_q;
    byteCnt_d  = byteCnt_q;
    holdCnt_d  = holdCnt_q;
    badIndex_d = badIndex_q;
    doneNow    = 1'b0;
    startNow   = 1'b0;
    startIdx   = bus.ioctl_index;
    case (state_q)
      S_IDLE: begin
        if (rise) startNow = 1'b1;
      end
      S_ACTIVE: begin
        if (push && byteCnt_q != CNT_MAX) byteCnt_d = byteCnt_q + (AW+1)'(1);
        if (!bus.ioctl_download) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rise) begin
          pend_d    = 1'b1;
          pendIdx_d = bus.ioctl_index;
        end
        if (count_q == '0) begin
          state_d   = S_HOLD;
          holdCnt_d = '0;
          doneNow   = 1'b1;
        end
      end
      default: begin
        if (rise && !pend_q) begin
          pend_d    = 1'b1;
          pendIdx_d = bus.ioctl_index;
        end
        if (!isRom || holdCnt_q == HOLD_LAST) begin
          if (pend_q || rise) begin
            startNow = 1'b1;
            startIdx = pend_q ? pendIdx_q : bus.ioctl_index;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          holdCnt_d = holdCnt_q + HW'(1);
        end
      end
    endcase
    if (startNow) begin
      state_d   = S_ACTIVE;
      curIdx_d  = startIdx;
      pend_d    = 1'b0;
      byteCnt_d = '0;
      if ({1'b0, startIdx} >= NSLOTS_W) badIndex_d = 1'b1;
    end
    coreReset_d = (state_d != S_IDLE) && (curIdx_d == ROM_W);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      curIdx_q    <= '0;
      pendIdx_q   <= '0;
      pend_q      <= 1'b0;
      dlPrev_q    <= 1'b0;
      byteCnt_q   <= '0;
      holdCnt_q   <= '0;
      badIndex_q  <= 1'b0;
      overflow_q  <= 1'b0;
      slotDone_q  <= '0;
      dnLen_q     <= '0;
      coreReset_q <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      curIdx_q    <= curIdx_d;
      pendIdx_q   <= pendIdx_d;
      pend_q      <= pend_d;
      dlPrev_q    <= bus.ioctl_download;
      byteCnt_q   <= byteCnt_d;
      holdCnt_q   <= holdCnt_d;
      badIndex_q  <= badIndex_d;
      overflow_q  <= overflow_q | ovfl;
      slotDone_q  <= doneNow ? slotOneHot : '0;
      coreReset_q <= coreReset_d;
      if (doneNow && validSlot) dnLen_q <= byteCnt_q;
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + (PW+1)'(1);
      else if (!push && pop) count_q <= count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      memAddr[wrPtr_q] <= bus.ioctl_addr;
      memData[wrPtr_q] <= bus.ioctl_dout;
      memSlot[wrPtr_q] <= curIdx_q[SW-1:0];
    end
  end

  assign bus.dn_wr       = count_q != '0;
  assign bus.dn_addr     = memAddr[rdPtr_q];
  assign bus.dn_data     = memData[rdPtr_q];
  assign bus.dn_slot     = memSlot[rdPtr_q];
  assign bus.ioctl_wait  = (count_q >= WAIT_LVL) || (state_q == S_DRAIN) || (state_q == S_HOLD);
  assign bus.slot_active = ((state_q == S_ACTIVE) || (state_q == S_DRAIN)) ? slotOneHot : '0;
  assign bus.slot_done   = slotDone_q;
  assign bus.dn_len      = dnLen_q;
  assign bus.bad_index   = badIndex_q;
  assign bus.overflow    = overflow_q;
  assign bus.core_reset  = coreReset_q;
endmodule

// File: tb/tb_ioctl_dl_router.sv
// Directed bench for ioctl_dl_router: ROM load, backpressure, overflow, bad index,
// back-to-back downloads and mid-operation reset, with a negedge capture of target writes.
module tb_ioctl_dl_router;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ioctl_dl_router_if #(.NSLOTS(4), .AW(16), .DW(8)) bus ();

  ioctl_dl_router #(
    .NSLOTS(4), .AW(16), .DW(8), .FIFO_DEPTH(8), .ROM_INDEX(0), .RESET_HOLD(16)
  ) dut (
    .clk_sys(clk),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct packed {
    logic [1:0]  slot;
    logic [15:0] addr;
    logic [7:0]  data;
  } rx_t;

  rx_t rxQ[$];
  int  doneCnt[4];
  int  checks = 0;
  int  passes = 0;

  // Every accepted target write and every completion pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.dn_wr && bus.dn_ready) rxQ.push_back(rx_t'({bus.dn_slot, bus.dn_addr, bus.dn_data}));
      for (int i = 0; i < 4; i++) if (bus.slot_done[i]) doneCnt[i]++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] dataFor(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dl, input logic wr, input logic [15:0] addr,
                               input logic [7:0] idx, input logic rdy);
    bus.ioctl_download = dl;
    bus.ioctl_wr       = wr;
    bus.ioctl_addr     = addr;
    bus.ioctl_dout     = dataFor(addr);
    bus.ioctl_index    = idx;
    bus.dn_ready       = rdy;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes = passes + 1;
    else $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic checkStream(input string tag, input int start, input int n,
                             input logic [1:0] slot, input logic [15:0] base);
    int errs;
    rx_t e;
    logic [15:0] a;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      if (start + i >= rxQ.size()) errs++;
      else begin
        e = rxQ[start + i];
        if (e.slot !== slot || e.addr !== a || e.data !== dataFor(a)) errs++;
      end
    end
    checkOutput(tag, errs, 0);
  endtask

  task automatic waitDone(input int slot, input int target, input string tag);
    for (int c = 0; c < 100 && doneCnt[slot] < target; c++) tick();
    checkOutput(tag, doneCnt[slot], target);
  endtask

  initial begin
    int found, hi, sent;
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_index    = '0;
    bus.dn_ready       = 1'b0;
    for (int i = 0; i < 4; i++) doneCnt[i] = 0;
    repeat (3) tick();
    checkOutput("rst_dn_wr", bus.dn_wr, 0);
    checkOutput("rst_wait", bus.ioctl_wait, 0);
    checkOutput("rst_core_reset", bus.core_reset, 0);
    checkOutput("rst_slot_active", bus.slot_active, 0);
    checkOutput("rst_flags", {bus.bad_index, bus.overflow}, 0);
    checkOutput("rst_dn_len", bus.dn_len, 0);
    reset = 1'b0;
    repeat (2) tick();

    $display("[TB] ROM load, 256 bytes");
    applyStimulus(1, 0, 16'h0000, 8'd0, 1);
    checkOutput("rom_core_reset_on", bus.core_reset, 1);
    checkOutput("rom_slot_active", bus.slot_active, 4'b0001);
    for (int i = 0; i < 256; i++) applyStimulus(1, 1, 16'(i), 8'd0, 1);
    checkOutput("rom_wait_low", bus.ioctl_wait, 0);
    applyStimulus(0, 0, 16'h0000, 8'd0, 1);
    checkOutput("rom_drain_wait", bus.ioctl_wait, 1);
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.slot_done[0]) begin
        found = 1;
        break;
      end
      tick();
    end
    checkOutput("rom_done_seen", found, 1);
    checkOutput("rom_dn_len", bus.dn_len, 256);
    hi = 0;
    while (bus.core_reset && hi < 40) begin
      hi++;
      tick();
    end
    checkOutput("rom_hold_cycles", hi, 16);
    checkOutput("rom_idle_wait", bus.ioctl_wait, 0);
    checkOutput("rom_rx_count", rxQ.size(), 256);
    checkStream("rom_stream", 0, 256, 2'd0, 16'h0000);
    checkOutput("rom_done_once", doneCnt[0], 1);

    $display("[TB] backpressure on slot 1");
    rxQ.delete();
    applyStimulus(1, 0, 16'h0000, 8'd1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 16'h0100 + 16'(i), 8'd1, 0);
    checkOutput("bp_wait_at5", bus.ioctl_wait, 0);
    applyStimulus(1, 1, 16'h0105, 8'd1, 0);
    checkOutput("bp_wait_at6", bus.ioctl_wait, 1);
    checkOutput("bp_dn_wr", bus.dn_wr, 1);
    checkOutput("bp_head", {bus.dn_slot, bus.dn_addr, bus.dn_data}, {2'd1, 16'h0100, dataFor(16'h0100)});
    checkOutput("bp_core_reset", bus.core_reset, 0);
    for (int c = 0; c < 13; c++) applyStimulus(1, 0, 16'h0000, 8'd1, 0);
    checkOutput("bp_head_stable", {bus.dn_addr, bus.dn_data}, {16'h0100, dataFor(16'h0100)});
    sent = 6;
    for (int c = 0; c < 40 && sent < 10; c++) begin
      if (!bus.ioctl_wait) begin
        applyStimulus(1, 1, 16'h0100 + 16'(sent), 8'd1, 1);
        sent++;
      end else applyStimulus(1, 0, 16'h0000, 8'd1, 1);
    end
    checkOutput("bp_sent", sent, 10);
    applyStimulus(0, 0, 16'h0000, 8'd1, 1);
    waitDone(1, 1, "bp_done");
    checkOutput("bp_dn_len", bus.dn_len, 10);
    checkOutput("bp_overflow", bus.overflow, 0);
    checkOutput("bp_rx_count", rxQ.size(), 10);
    checkStream("bp_stream", 0, 10, 2'd1, 16'h0100);

    $display("[TB] overflow on slot 2");
    rxQ.delete();
    applyStimulus(1, 0, 16'h0000, 8'd2, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 16'h0200 + 16'(i), 8'd2, 0);
    checkOutput("ov_flag", bus.overflow, 1);
    checkOutput("ov_wait", bus.ioctl_wait, 1);
    applyStimulus(0, 0, 16'h0000, 8'd2, 1);
    waitDone(2, 1, "ov_done");
    checkOutput("ov_dn_len", bus.dn_len, 8);
    checkOutput("ov_rx_count", rxQ.size(), 8);
    checkStream("ov_stream", 0, 8, 2'd2, 16'h0200);

    $display("[TB] bad index 7");
    rxQ.delete();
    applyStimulus(1, 0, 16'h0000, 8'd7, 1);
    checkOutput("bad_flag", bus.bad_index, 1);
    checkOutput("bad_slot_active", bus.slot_active, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 16'h0700 + 16'(i), 8'd7, 1);
    applyStimulus(0, 0, 16'h0000, 8'd7, 1);
    checkOutput("bad_drain_wait", bus.ioctl_wait, 1);
    for (int c = 0; c < 20 && bus.ioctl_wait; c++) tick();
    checkOutput("bad_wait_released", bus.ioctl_wait, 0);
    checkOutput("bad_rx_count", rxQ.size(), 0);
    checkOutput("bad_no_done", doneCnt[0] + doneCnt[1] + doneCnt[2] + doneCnt[3], 3);
    checkOutput("bad_sticky", {bus.bad_index, bus.overflow}, 2'b11);

    $display("[TB] ROM then CAS back-to-back");
    rxQ.delete();
    applyStimulus(1, 0, 16'h0000, 8'd0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 16'h0300 + 16'(i), 8'd0, 0);
    applyStimulus(0, 0, 16'h0000, 8'd0, 0);
    applyStimulus(1, 0, 16'h0000, 8'd1, 0);
    checkOutput("b2b_rom_active", bus.slot_active, 4'b0001);
    checkOutput("b2b_rom_core_reset", bus.core_reset, 1);
    for (int c = 0; c < 60; c++) begin
      if (!bus.ioctl_wait) break;
      applyStimulus(1, 0, 16'h0000, 8'd1, 1);
    end
    checkOutput("b2b_cas_wait", bus.ioctl_wait, 0);
    checkOutput("b2b_cas_active", bus.slot_active, 4'b0010);
    checkOutput("b2b_cas_core_reset", bus.core_reset, 0);
    checkOutput("b2b_rom_done", doneCnt[0], 2);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 16'h0400 + 16'(i), 8'd5, 1);
    applyStimulus(0, 0, 16'h0000, 8'd5, 1);
    waitDone(1, 2, "b2b_cas_done");
    checkOutput("b2b_dn_len", bus.dn_len, 3);
    checkOutput("b2b_rx_count", rxQ.size(), 9);
    checkStream("b2b_rom_stream", 0, 6, 2'd0, 16'h0300);
    checkStream("b2b_cas_stream", 6, 3, 2'd1, 16'h0400);

    $display("[TB] reset with 5 queued entries");
    rxQ.delete();
    applyStimulus(1, 0, 16'h0000, 8'd0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 16'h0500 + 16'(i), 8'd0, 0);
    checkOutput("mr_dn_wr_before", bus.dn_wr, 1);
    checkOutput("mr_core_reset_before", bus.core_reset, 1);
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("mr_dn_wr_async", bus.dn_wr, 0);
    checkOutput("mr_core_reset", bus.core_reset, 0);
    checkOutput("mr_wait", bus.ioctl_wait, 0);
    checkOutput("mr_flags_cleared", {bus.bad_index, bus.overflow}, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    rxQ.delete();
    applyStimulus(1, 0, 16'h0000, 8'd1, 1);
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, 16'h0600 + 16'(i), 8'd1, 1);
    applyStimulus(0, 0, 16'h0000, 8'd1, 1);
    waitDone(1, 3, "mr_fresh_done");
    checkOutput("mr_fresh_len", bus.dn_len, 2);
    checkOutput("mr_fresh_rx_count", rxQ.size(), 2);
    checkStream("mr_fresh_stream", 0, 2, 2'd1, 16'h0600);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
